// File: rtl/tmr_shift_register_scrub.sv
// -----------------------------------------------------------------------------
// tmr_shift_register_scrub
//
// Purpose:
//    Triple-modular-redundant multi-mode shift register. Three replicas of the
//    data word are held. The output is a vote over them. Every replica computes
//    its next state from the voted word, so any replica that disagrees with the
//    vote is corrected at the next edge, whether or not enable is high. Each
//    replica has a saturating mismatch counter, a sticky fault flag and a
//    retirement flag. A retired replica is still scrubbed and counted, but it
//    no longer takes part in the vote. A fault-injection port can flip bits in
//    one chosen replica.
//
// Ports:
//    clk            in   rising-edge clock
//    rst            in   asynchronous reset, active-low
//    enable         in   functional update enable
//    mode           in   00 SISO right, 01 SISO left, 10 PISO, 11 PIPO
//    load           in   parallel load (modes 10/11)
//    serial_in      in   serial data in
//    parallel_in    in   parallel data in
//    clear_faults   in   synchronous clear of counters, sticky and failed flags
//    inject_en      in   flip inject_mask bits in replica inject_sel this edge
//    inject_sel     in   replica 0..2; 3 selects no replica
//    inject_mask    in   bits to flip
//    parallel_out   out  voted word
//    serial_out     out  voted serial bit
//    fault_vec      out  replica i differs from the voted word (combinational)
//    fault_sticky   out  replica i mismatched since the last clear
//    replica_failed out  replica i retired since the last clear
//    fault_cnt      out  replica i mismatch count at [i*FAULT_CNT_W +: FAULT_CNT_W]
//    uncorrectable  out  healthy replicas cannot form a majority
// -----------------------------------------------------------------------------
module tmr_shift_register_scrub #(
   parameter int WIDTH        = 8,
   parameter int FAULT_CNT_W  = 4,
   parameter int FAULT_THRESH = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic [1:0]               mode,
   input  logic                     load,
   input  logic                     serial_in,
   input  logic [WIDTH-1:0]         parallel_in,
   input  logic                     clear_faults,
   input  logic                     inject_en,
   input  logic [1:0]               inject_sel,
   input  logic [WIDTH-1:0]         inject_mask,
   output logic [WIDTH-1:0]         parallel_out,
   output logic                     serial_out,
   output logic [2:0]               fault_vec,
   output logic [2:0]               fault_sticky,
   output logic [2:0]               replica_failed,
   output logic [3*FAULT_CNT_W-1:0] fault_cnt,
   output logic                     uncorrectable
);

   localparam logic [FAULT_CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [FAULT_CNT_W-1:0] THRESH_C = FAULT_CNT_W'(FAULT_THRESH);

   logic [WIDTH-1:0]       rep_reg    [3];
   logic [WIDTH-1:0]       rep_next   [3];
   logic [FAULT_CNT_W-1:0] cnt_reg    [3];
   logic [FAULT_CNT_W-1:0] cnt_next   [3];
   logic [2:0]             sticky_reg;
   logic [2:0]             sticky_next;
   logic [2:0]             failed_reg;
   logic [2:0]             failed_next;

   logic [WIDTH-1:0]       majority;
   logic [WIDTH-1:0]       voted;
   logic [WIDTH-1:0]       base_next;

   // ---------------------------------------------------------------- vote
   assign majority = (rep_reg[0] & rep_reg[1]) |
                     (rep_reg[0] & rep_reg[2]) |
                     (rep_reg[1] & rep_reg[2]);

   // Once any replica is retired a bitwise majority is no longer meaningful,
   // so the lowest-index healthy replica is trusted instead. With nothing
   // healthy left, R0 is used as the least-bad choice.
   always_comb begin
      voted = majority;
      if (failed_reg != 3'b000) begin
         if (!failed_reg[0])      voted = rep_reg[0];
         else if (!failed_reg[1]) voted = rep_reg[1];
         else if (!failed_reg[2]) voted = rep_reg[2];
         else                     voted = rep_reg[0];
      end
   end

   // With one retired replica the remaining pair must agree; with two or more
   // retired there is no redundancy left at all.
   always_comb begin
      uncorrectable = 1'b0;
      case (failed_reg)
         3'b000:  uncorrectable = 1'b0;
         3'b001:  uncorrectable = (rep_reg[1] != rep_reg[2]);
         3'b010:  uncorrectable = (rep_reg[0] != rep_reg[2]);
         3'b100:  uncorrectable = (rep_reg[0] != rep_reg[1]);
         default: uncorrectable = 1'b1;
      endcase
   end

   assign parallel_out = voted;
   assign serial_out   = mode[0] ? voted[WIDTH-1] : voted[0];

   // ---------------------------------------------------------------- next word
   // All replicas start from the voted word. This is what scrubs a bad replica,
   // including when enable is low (the replicas simply reload the vote).
   always_comb begin
      base_next = voted;
      if (enable) begin
         case (mode)
            2'b00:   base_next = {serial_in, voted[WIDTH-1:1]};
            2'b01:   base_next = {voted[WIDTH-2:0], serial_in};
            2'b10:   base_next = load ? parallel_in : {1'b0, voted[WIDTH-1:1]};
            default: base_next = load ? parallel_in : voted;
         endcase
      end
   end

   // ---------------------------------------------------------------- per replica
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_rep
         logic [FAULT_CNT_W-1:0] cnt_inc;
         logic                   inj_hit;

         assign inj_hit       = inject_en && (inject_sel == 2'(gi));
         assign rep_next[gi]  = base_next ^ (inj_hit ? inject_mask : '0);
         assign fault_vec[gi] = (rep_reg[gi] != voted);
         assign cnt_inc       = (cnt_reg[gi] == CNT_MAX) ? cnt_reg[gi]
                                                         : cnt_reg[gi] + 1'b1;

         // Clear takes priority over a mismatch seen on the same edge.
         always_comb begin
            cnt_next[gi]    = cnt_reg[gi];
            sticky_next[gi] = sticky_reg[gi];
            failed_next[gi] = failed_reg[gi];
            if (clear_faults) begin
               cnt_next[gi]    = '0;
               sticky_next[gi] = 1'b0;
               failed_next[gi] = 1'b0;
            end else if (fault_vec[gi]) begin
               cnt_next[gi]    = cnt_inc;
               sticky_next[gi] = 1'b1;
               if (cnt_inc >= THRESH_C) failed_next[gi] = 1'b1;
            end
         end

         assign fault_cnt[gi*FAULT_CNT_W +: FAULT_CNT_W] = cnt_reg[gi];
      end
   endgenerate

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 3; i++) begin
            rep_reg[i] <= '0;
            cnt_reg[i] <= '0;
         end
         sticky_reg <= '0;
         failed_reg <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            rep_reg[i] <= rep_next[i];
            cnt_reg[i] <= cnt_next[i];
         end
         sticky_reg <= sticky_next;
         failed_reg <= failed_next;
      end
   end

   assign fault_sticky   = sticky_reg;
   assign replica_failed = failed_reg;

endmodule

// File: tb/tb_tmr_shift_register_scrub.sv
// -----------------------------------------------------------------------------
// tb_tmr_shift_register_scrub
//
// Purpose:
//    Self-checking bench for tmr_shift_register_scrub (WIDTH=8, FAULT_CNT_W=4,
//    FAULT_THRESH=3). The stimulus process drives inputs on the falling edge,
//    advances an abstract model of the three replicas and pushes the expected
//    outputs into a scoreboard. A monitor pops and compares after every rising
//    edge, and right after an asynchronous reset assertion.
// -----------------------------------------------------------------------------
module tb_tmr_shift_register_scrub;

   localparam int W  = 8;
   localparam int CW = 4;
   localparam int TH = 3;
   localparam int CNT_SAT = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic [1:0]    mode = 2'b00;
   logic          load = 1'b0;
   logic          serial_in = 1'b0;
   logic [W-1:0]  parallel_in = '0;
   logic          clear_faults = 1'b0;
   logic          inject_en = 1'b0;
   logic [1:0]    inject_sel = 2'd3;
   logic [W-1:0]  inject_mask = '0;
   logic [W-1:0]  parallel_out;
   logic          serial_out;
   logic [2:0]    fault_vec;
   logic [2:0]    fault_sticky;
   logic [2:0]    replica_failed;
   logic [3*CW-1:0] fault_cnt;
   logic          uncorrectable;

   tmr_shift_register_scrub #(.WIDTH(W), .FAULT_CNT_W(CW), .FAULT_THRESH(TH)) dut (
      .clk(clk), .rst(rst), .enable(enable), .mode(mode), .load(load),
      .serial_in(serial_in), .parallel_in(parallel_in),
      .clear_faults(clear_faults), .inject_en(inject_en),
      .inject_sel(inject_sel), .inject_mask(inject_mask),
      .parallel_out(parallel_out), .serial_out(serial_out),
      .fault_vec(fault_vec), .fault_sticky(fault_sticky),
      .replica_failed(replica_failed), .fault_cnt(fault_cnt),
      .uncorrectable(uncorrectable)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [7:0]  po;
      logic        so;
      logic [2:0]  fv;
      logic [2:0]  st;
      logic [2:0]  fl;
      logic [11:0] cnt;
      logic        unc;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   txn_id   = 0;

   // ---------------------------------------------------------------- model
   logic [7:0] m_rep [3];
   int         m_cnt [3];
   bit         m_st  [3];
   bit         m_fl  [3];

   function automatic void m_reset();
      for (int i = 0; i < 3; i++) begin
         m_rep[i] = '0; m_cnt[i] = 0; m_st[i] = 0; m_fl[i] = 0;
      end
   endfunction

   function automatic logic [7:0] m_vote();
      logic [7:0] v;
      int ones;
      v = '0;
      if (!m_fl[0] && !m_fl[1] && !m_fl[2]) begin
         for (int b = 0; b < 8; b++) begin
            ones = int'(m_rep[0][b]) + int'(m_rep[1][b]) + int'(m_rep[2][b]);
            v[b] = (ones >= 2);
         end
         return v;
      end
      for (int i = 0; i < 3; i++) if (!m_fl[i]) return m_rep[i];
      return m_rep[0];
   endfunction

   function automatic logic m_unc();
      int nf;
      logic [7:0] h [$];
      nf = 0;
      for (int i = 0; i < 3; i++) begin
         if (m_fl[i]) nf++;
         else h.push_back(m_rep[i]);
      end
      if (nf >= 2) return 1'b1;
      if (nf == 1) return (h[0] != h[1]);
      return 1'b0;
   endfunction

   function automatic exp_t m_expect(input logic [1:0] md);
      exp_t e;
      logic [7:0] v;
      v = m_vote();
      e.id  = txn_id;
      e.po  = v;
      e.so  = md[0] ? v[7] : v[0];
      e.unc = m_unc();
      e.cnt = '0;
      for (int i = 0; i < 3; i++) begin
         e.fv[i] = (m_rep[i] != v);
         e.st[i] = m_st[i];
         e.fl[i] = m_fl[i];
         e.cnt[i*CW +: CW] = 4'(m_cnt[i]);
      end
      return e;
   endfunction

   // Drive one clock's worth of inputs (caller is at a falling edge), advance
   // the model over the coming rising edge and queue what must be seen after it.
   task automatic drive(input logic en, input logic [1:0] md, input logic ld,
                        input logic si, input logic [7:0] pin, input logic clr,
                        input logic ie, input logic [1:0] isel,
                        input logic [7:0] imask);
      logic [7:0] v;
      int vi, nb;
      bit mis;
      enable = en; mode = md; load = ld; serial_in = si; parallel_in = pin;
      clear_faults = clr; inject_en = ie; inject_sel = isel; inject_mask = imask;

      v  = m_vote();
      vi = int'(v);
      nb = vi;
      if (en) begin
         case (md)
            2'd0:    nb = vi / 2 + int'(si) * 128;
            2'd1:    nb = (vi * 2) % 256 + int'(si);
            2'd2:    nb = ld ? int'(pin) : vi / 2;
            default: nb = ld ? int'(pin) : vi;
         endcase
      end
      for (int i = 0; i < 3; i++) begin
         mis = (m_rep[i] != v);
         m_rep[i] = 8'(nb) ^ ((ie && int'(isel) == i) ? imask : 8'h00);
         if (clr) begin
            m_cnt[i] = 0; m_st[i] = 0; m_fl[i] = 0;
         end else if (mis) begin
            if (m_cnt[i] < CNT_SAT) m_cnt[i]++;
            m_st[i] = 1;
            if (m_cnt[i] >= TH) m_fl[i] = 1;
         end
      end
      txn_id++;
      sb_q.push_back(m_expect(md));
   endtask

   task automatic idle();
      drive(1'b0, 2'b11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd3, 8'h00);
   endtask

   // Called just after a falling edge: assert reset between edges, expect all
   // outputs cleared immediately, hold it across one rising edge, release.
   task automatic async_reset();
      exp_t e;
      #2;
      m_reset();
      txn_id++;
      e = m_expect(mode);
      sb_q.push_back(e);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   // ---------------------------------------------------------------- monitor
   function automatic bit chk(input int id, input string name,
                              input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL txn %0d %s: got %0h, required %0h", id, name, act, req);
         return 1'b0;
      end
      return 1'b1;
   endfunction

   initial begin : monitor
      exp_t e;
      int bad;
      forever begin
         @(posedge clk or negedge rst);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            bad = 0;
            if (!chk(e.id, "parallel_out",   32'(parallel_out),   32'(e.po)))  bad++;
            if (!chk(e.id, "serial_out",     32'(serial_out),     32'(e.so)))  bad++;
            if (!chk(e.id, "fault_vec",      32'(fault_vec),      32'(e.fv)))  bad++;
            if (!chk(e.id, "fault_sticky",   32'(fault_sticky),   32'(e.st)))  bad++;
            if (!chk(e.id, "replica_failed", 32'(replica_failed), 32'(e.fl)))  bad++;
            if (!chk(e.id, "fault_cnt",      32'(fault_cnt),      32'(e.cnt))) bad++;
            if (!chk(e.id, "uncorrectable",  32'(uncorrectable),  32'(e.unc))) bad++;
            $display("txn %0d po=%02h so=%0b fv=%03b st=%03b fl=%03b cnt=%03h unc=%0b errors=%0d",
                     e.id, parallel_out, serial_out, fault_vec, fault_sticky,
                     replica_failed, fault_cnt, uncorrectable, bad);
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "timeout");
   end

   // ---------------------------------------------------------------- stimulus
   initial begin : stimulus
      logic [7:0] bits;
      m_reset();
      async_reset();                        // reset state check, release at a falling edge

      // Parallel load then scrub of a single flipped bit.
      drive(1'b1, 2'b11, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 2'd3, 8'h00);
      @(negedge clk); drive(1'b0, 2'b11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 8'h01);
      @(negedge clk); idle();

      // SISO right shift from zero with serial pattern 1,0,1,1.
      @(negedge clk); drive(1'b1, 2'b11, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd3, 8'h00);
      bits = 8'b0000_1101;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); drive(1'b1, 2'b00, 1'b0, bits[k], 8'h00, 1'b0, 1'b0, 2'd3, 8'h00);
      end

      // Retire R2 via three separated injections, then disturb R0.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); drive(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd2, 8'h04);
         @(negedge clk); idle();
      end
      @(negedge clk); drive(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 8'h10);
      @(negedge clk); idle();
      @(negedge clk); idle();

      // Clear coincident with an R1 mismatch.
      @(negedge clk); drive(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd1, 8'h20);
      @(negedge clk); drive(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd3, 8'h00);
      @(negedge clk); idle();

      // Continuous R0 injection drives its counter into saturation.
      for (int k = 0; k < 20; k++) begin
         @(negedge clk); drive(1'b0, 2'b11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 8'h81);
      end
      @(negedge clk); idle();
      @(negedge clk); drive(1'b0, 2'b11, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd3, 8'h00);

      // Reset in the middle of a shift sequence holding 0x5A.
      @(negedge clk); drive(1'b1, 2'b11, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 2'd3, 8'h00);
      @(negedge clk); drive(1'b1, 2'b00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 2'd3, 8'h00);
      @(negedge clk); drive(1'b1, 2'b00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 2'd3, 8'h00);
      @(negedge clk); async_reset();
      drive(1'b1, 2'b00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 2'd3, 8'h00);

      // Randomised traffic with occasional mid-run resets.
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (k == 170 || k == 330) async_reset();
         drive(($urandom % 4) != 0, 2'($urandom % 4), 1'($urandom % 2),
               1'($urandom % 2), 8'($urandom), ($urandom % 24) == 0,
               ($urandom % 3) == 0, 2'($urandom % 4), 8'($urandom_range(1, 255)));
      end

      @(negedge clk); idle();
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
